cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
Parametrised, fully clocked coprocessor-0 for the Minisys-1A CPU, sitting beside the write-back stage. It holds the Count, Compare, Status, Cause and EPC registers and takes exceptions and a configurable number of hardware interrupts. It serves mfc0/mtc0/eret and produces a one-cycle PC redirect with a target address for the fetch stage. It also provides a Count/Compare timer interrupt.

Parameters:
NUM_HW_INT, 5, number of external interrupt lines (1..5), mapped to Cause.IP[10+i]
EXC_VECTOR, 32'h0000F000, single entry address for all exceptions and interrupts
COUNT_DIV, 2, clock cycles per Count increment (>=1)

Ports:
clock  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock
pc  in  32  PC of the instruction in write-back
exc_req  in  1  synchronous exception from the pipeline this cycle
exc_code  in  5  ExcCode for exc_req
int_in  in  NUM_HW_INT  level-sensitive hardware interrupt lines
mfc0  in  1  read request
mtc0  in  1  write request
eret  in  1  exception return
reg_addr  in  5  CP0 register number for mfc0/mtc0
wdata  in  32  mtc0 data
rdata  out  32  mfc0 data (combinational)
int_take  out  1  an interrupt is being taken this cycle (combinational)
redirect  out  1  one-cycle PC redirect pulse (registered)
redirect_pc  out  32  redirect target, valid while redirect=1
status_ie  out  1  Status.IE
status_ksu  out  2  Status.KSU
timer_irq  out  1  sticky timer-interrupt flag

Behaviour:
- Register map:
  - Count=9, Compare=11.
  - Status=12: IE[0], EXL[1], KSU[4:3], IM[15:8].
  - Cause=13: ExcCode[6:2], IP[15:8].
  - EPC=14.
  - All other numbers read as 0; mtc0 to them is ignored.
- Cause.IP bits:
  - IP[9:8] are software bits, writable by mtc0.
  - IP[10+i] = int_in[i], sampled every cycle.
  - IP[15] = timer_irq.
  - Remaining IP bits read as 0.
- Reset (reset=0 at a clock edge):
  - All registers 0, except Compare=32'hFFFFFFFF.
  - Prescaler=0, shadow IE/KSU=0, redirect=0, redirect_pc=0, timer_irq=0.
  - Outputs status_ie=0, status_ksu=0. rdata and int_take follow from the reset state.
  - Reset wins over every other input in the same cycle.
- Interrupt condition: int_take = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Per-cycle priority: entry (exc_req | int_take) > eret > mtc0. A lower-priority request in the same cycle is dropped.
- Entry, applied at the edge:
  - If EXL=0: EPC<=pc, shadow IE<=Status.IE, shadow KSU<=Status.KSU.
  - If EXL=1 (nested entry): EPC and shadow are left unchanged.
  - ExcCode<=exc_code when exc_req=1, else 0 (interrupt). exc_req wins over int_take.
  - Status.IE<=0, KSU<=0, EXL<=1.
  - Next cycle: redirect=1, redirect_pc=EXC_VECTOR.
- Eret:
  - Status.IE<=shadow IE, KSU<=shadow KSU, EXL<=0.
  - Next cycle: redirect=1, redirect_pc=EPC value before the edge.
  - Eret with EXL=0 still redirects to EPC.
- redirect stays high for exactly one cycle unless a new entry or eret arrives in the following cycle.
- mtc0:
  - Writes take effect at the edge.
  - mfc0 to the same address in the same cycle returns the old value.
  - Writing Cause changes only IP[9:8].
  - Writing Status changes IE, EXL, KSU and IM only.
  - Writing Compare clears timer_irq.
  - Writing Count loads it and clears the prescaler; the write wins over an increment in the same cycle.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments by 1 when the prescaler wraps.
  - Count wraps from 32'hFFFFFFFF to 0.
  - timer_irq is set on the cycle Count becomes equal to Compare through an increment, and stays set until a Compare write or reset.
  - A simultaneous Compare write and match leaves timer_irq cleared.

Test Plan:
- Reset released, no stimulus:
  - mfc0 reg 12 -> 0; reg 11 -> 32'hFFFFFFFF; reg 9 -> 0.
  - With COUNT_DIV=2, reg 9 reads 5 after 10 cycles.
- Syscall entry: exc_req=1, exc_code=8, pc=32'h100, Status=32'h0000_0019 (IE=1, KSU=3):
  - Next cycle: redirect=1, redirect_pc=32'h0000F000, EPC=32'h100, Cause[6:2]=8, Status IE=0, KSU=0, EXL=1.
  - Then eret: redirect_pc=32'h100, Status back to IE=1, KSU=3, EXL=0.
- Hardware interrupt: Status IM[10]=1, IE=1, int_in[0]=1:
  - int_take=1 and ExcCode=0.
  - A second int_in while EXL=1 -> no further entry.
  - exc_req while EXL=1 -> EPC unchanged, ExcCode updated.
- Timer: mtc0 Count=32'hFFFFFFFE, Compare=1, COUNT_DIV=1:
  - Count wraps to 0, timer_irq=1 three cycles after the Count write.
  - mtc0 Compare -> timer_irq=0.
- Priority: exc_req, eret and mtc0 Status asserted together -> entry only; Status write dropped.
- Reset asserted mid-redirect -> redirect=0 next cycle and all registers return to their reset values.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the Minisys-1A CPU. It holds Count/Compare/Status/Cause/EPC,
// takes exceptions and interrupts, and issues a one-cycle PC redirect to fetch.
module cp0_unit #(
   parameter int          NUM_HW_INT = 5,
   parameter logic [31:0] EXC_VECTOR = 32'h0000F000,
   parameter int          COUNT_DIV  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           pc,
   input  logic                  exc_req,
   input  logic [4:0]            exc_code,
   input  logic [NUM_HW_INT-1:0] int_in,
   input  logic                  mfc0,
   input  logic                  mtc0,
   input  logic                  eret,
   input  logic [4:0]            reg_addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  int_take,
   output logic                  redirect,
   output logic [31:0]           redirect_pc,
   output logic                  status_ie,
   output logic [1:0]            status_ksu,
   output logic                  timer_irq
);

   localparam int             PW      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0]  PS_LAST = PW'(COUNT_DIV - 1);

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_STATUS  = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;

   logic [31:0]           r_count;
   logic [31:0]           r_compare;
   logic [PW-1:0]         r_prescaler;
   logic                  r_ie;
   logic                  r_exl;
   logic [1:0]            r_ksu;
   logic [7:0]            r_im;
   logic [4:0]            r_exc_code;
   logic [1:0]            r_ip_sw;
   logic [NUM_HW_INT-1:0] r_ip_hw;
   logic [31:0]           r_epc;
   logic                  r_shadow_ie;
   logic [1:0]            r_shadow_ksu;
   logic                  r_redirect;
   logic [31:0]           r_redirect_pc;
   logic                  r_timer_irq;

   logic [7:0]  w_ip;
   logic        w_int_take;
   logic        w_entry;
   logic        w_eret;
   logic        w_wr;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_tick;
   logic [31:0] w_count_inc;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic [31:0] w_rd;

   // Cause.IP: [1:0] software, [2+i] hardware lines, [7] timer; the rest read as 0.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch is inferred.
      w_ip      = '0;
      w_ip[1:0] = r_ip_sw;
      for (int i = 0; i < NUM_HW_INT; i++) w_ip[2+i] = r_ip_hw[i];
      w_ip[7]   = r_timer_irq;
   end

   assign w_int_take   = r_ie & ~r_exl & |(w_ip & r_im);
   assign w_entry      = exc_req | w_int_take;
   assign w_eret       = eret & ~w_entry;
   assign w_wr         = mtc0 & ~w_entry & ~w_eret;
   assign w_wr_count   = w_wr && (reg_addr == A_COUNT);
   assign w_wr_compare = w_wr && (reg_addr == A_COMPARE);
   assign w_tick       = (r_prescaler == PS_LAST);
   assign w_count_inc  = r_count + 32'd1;

   assign w_status = {16'h0, r_im, 3'b000, r_ksu, 1'b0, r_exl, r_ie};
   assign w_cause  = {16'h0, w_ip, 1'b0, r_exc_code, 2'b00};

   always_comb begin
      w_rd = '0;
      case (reg_addr)
         A_COUNT:   w_rd = r_count;
         A_COMPARE: w_rd = r_compare;
         A_STATUS:  w_rd = w_status;
         A_CAUSE:   w_rd = w_cause;
         A_EPC:     w_rd = r_epc;
         default:   w_rd = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_count       <= '0;
         r_compare     <= 32'hFFFF_FFFF;
         r_prescaler   <= '0;
         r_ie          <= 1'b0;
         r_exl         <= 1'b0;
         r_ksu         <= '0;
         r_im          <= '0;
         r_exc_code    <= '0;
         r_ip_sw       <= '0;
         r_ip_hw       <= '0;
         r_epc         <= '0;
         r_shadow_ie   <= 1'b0;
         r_shadow_ksu  <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_timer_irq   <= 1'b0;
      end else begin
         r_ip_hw <= int_in;

         // A Count write reloads and restarts the prescaler, overriding the tick.
         if (w_wr_count) begin
            r_count     <= wdata;
            r_prescaler <= '0;
         end else if (w_tick) begin
            r_count     <= w_count_inc;
            r_prescaler <= '0;
         end else begin
            r_prescaler <= r_prescaler + PW'(1);
         end

         if (w_wr_compare) begin
            r_compare   <= wdata;
            r_timer_irq <= 1'b0;
         end else if (!w_wr_count && w_tick && (w_count_inc == r_compare)) begin
            r_timer_irq <= 1'b1;
         end

         r_redirect <= w_entry | w_eret;

         if (w_entry) begin
            // A nested entry keeps the EPC and shadow of the outer one.
            if (!r_exl) begin
               r_epc        <= pc;
               r_shadow_ie  <= r_ie;
               r_shadow_ksu <= r_ksu;
            end
            r_exc_code    <= exc_req ? exc_code : 5'd0;
            r_ie          <= 1'b0;
            r_ksu         <= '0;
            r_exl         <= 1'b1;
            r_redirect_pc <= EXC_VECTOR;
         end else if (w_eret) begin
            r_ie          <= r_shadow_ie;
            r_ksu         <= r_shadow_ksu;
            r_exl         <= 1'b0;
            r_redirect_pc <= r_epc;
         end else if (w_wr) begin
            case (reg_addr)
               A_STATUS: begin
                  r_ie  <= wdata[0];
                  r_exl <= wdata[1];
                  r_ksu <= wdata[4:3];
                  r_im  <= wdata[15:8];
               end
               A_CAUSE: r_ip_sw <= wdata[9:8];
               A_EPC:   r_epc   <= wdata;
               default: ;
            endcase
         end
      end
   end

   assign rdata       = mfc0 ? w_rd : 32'h0;
   assign int_take    = w_int_take;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign status_ie   = r_ie;
   assign status_ksu  = r_ksu;
   assign timer_irq   = r_timer_irq;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: one instance with COUNT_DIV=2 and one with
// COUNT_DIV=1 share all inputs; expectations are queued at drive time.
module tb_cp0_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [4:0]  int_in;
   logic        mfc0, mtc0, eret;
   logic [4:0]  reg_addr;
   logic [31:0] wdata;

   logic [31:0] rdata, rdata1;
   logic        int_take, int_take1;
   logic        redirect, redirect1;
   logic [31:0] redirect_pc, redirect_pc1;
   logic        status_ie, status_ie1;
   logic [1:0]  status_ksu, status_ksu1;
   logic        timer_irq, timer_irq1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   cp0_unit #(.NUM_HW_INT(5), .EXC_VECTOR(32'h0000F000), .COUNT_DIV(2)) u_dut (
      .clock(clock), .reset(reset), .pc(pc), .exc_req(exc_req), .exc_code(exc_code),
      .int_in(int_in), .mfc0(mfc0), .mtc0(mtc0), .eret(eret), .reg_addr(reg_addr),
      .wdata(wdata), .rdata(rdata), .int_take(int_take), .redirect(redirect),
      .redirect_pc(redirect_pc), .status_ie(status_ie), .status_ksu(status_ksu),
      .timer_irq(timer_irq)
   );

   cp0_unit #(.NUM_HW_INT(5), .EXC_VECTOR(32'h0000F000), .COUNT_DIV(1)) u_dut1 (
      .clock(clock), .reset(reset), .pc(pc), .exc_req(exc_req), .exc_code(exc_code),
      .int_in(int_in), .mfc0(mfc0), .mtc0(mtc0), .eret(eret), .reg_addr(reg_addr),
      .wdata(wdata), .rdata(rdata1), .int_take(int_take1), .redirect(redirect1),
      .redirect_pc(redirect_pc1), .status_ie(status_ie1), .status_ksu(status_ksu1),
      .timer_irq(timer_irq1)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled before the next edge.
   task automatic cycle();
      @(posedge clock);
      #2;
   endtask

   task automatic rd(input int which, input logic [4:0] addr, input logic [31:0] exp, input string tag);
      sb_push(tag, exp);
      mfc0     = 1'b1;
      reg_addr = addr;
      #1;
      sb_pop(which == 1 ? rdata1 : rdata);
      mfc0 = 1'b0;
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      mtc0     = 1'b1;
      reg_addr = addr;
      wdata    = data;
      cycle();
      mtc0 = 1'b0;
   endtask

   task automatic chk_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      sb_push(tag, exp);
      sb_pop(obs);
   endtask

   initial begin
      reset = 1'b0; pc = '0; exc_req = 1'b0; exc_code = '0; int_in = '0;
      mfc0 = 1'b0; mtc0 = 1'b0; eret = 1'b0; reg_addr = '0; wdata = '0;
      repeat (3) cycle();
      reset = 1'b1;

      // Reset state
      rd(0, 5'd12, 32'h0, "rst_status");
      rd(0, 5'd11, 32'hFFFF_FFFF, "rst_compare");
      rd(0, 5'd9, 32'h0, "rst_count");
      chk_now("rst_redirect", 32'(redirect), 32'h0);
      chk_now("rst_timer_irq", 32'(timer_irq), 32'h0);
      chk_now("rst_int_take", 32'(int_take), 32'h0);

      repeat (10) cycle();
      rd(0, 5'd9, 32'd5, "count_div2_10cyc");
      rd(1, 5'd9, 32'd10, "count_div1_10cyc");

      // Syscall entry and return
      wr(5'd12, 32'h0000_0019);
      chk_now("pre_sys_ie", 32'(status_ie), 32'h1);
      chk_now("pre_sys_ksu", 32'(status_ksu), 32'h3);
      sb_push("sys_redirect", 32'h1);
      sb_push("sys_redirect_pc", 32'h0000_F000);
      pc = 32'h100; exc_req = 1'b1; exc_code = 5'd8;
      cycle();
      exc_req = 1'b0;
      sb_pop(32'(redirect));
      sb_pop(redirect_pc);
      rd(0, 5'd14, 32'h100, "sys_epc");
      rd(0, 5'd13, 32'h20, "sys_cause");
      rd(0, 5'd12, 32'h2, "sys_status");
      chk_now("sys_ie", 32'(status_ie), 32'h0);
      chk_now("sys_ksu", 32'(status_ksu), 32'h0);
      sb_push("sys_redirect_1cyc", 32'h0);
      cycle();
      sb_pop(32'(redirect));

      sb_push("eret_redirect", 32'h1);
      sb_push("eret_redirect_pc", 32'h100);
      eret = 1'b1;
      cycle();
      eret = 1'b0;
      sb_pop(32'(redirect));
      sb_pop(redirect_pc);
      rd(0, 5'd12, 32'h19, "eret_status");
      chk_now("eret_ie", 32'(status_ie), 32'h1);
      chk_now("eret_ksu", 32'(status_ksu), 32'h3);
      cycle();
      chk_now("eret_redirect_1cyc", 32'(redirect), 32'h0);

      // Hardware interrupt, then a second line and an exception while EXL=1
      wr(5'd12, 32'h0000_0401);
      pc = 32'h200; int_in = 5'b00001;
      cycle();
      chk_now("hw_int_take", 32'(int_take), 32'h1);
      sb_push("hw_redirect", 32'h1);
      sb_push("hw_redirect_pc", 32'h0000_F000);
      cycle();
      sb_pop(32'(redirect));
      sb_pop(redirect_pc);
      rd(0, 5'd13, 32'h400, "hw_cause");
      rd(0, 5'd14, 32'h200, "hw_epc");
      int_in = 5'b00011;
      #1;
      chk_now("hw_nested_int_take", 32'(int_take), 32'h0);
      sb_push("hw_nested_no_redirect", 32'h0);
      cycle();
      sb_pop(32'(redirect));

      sb_push("nest_redirect", 32'h1);
      pc = 32'h300; exc_req = 1'b1; exc_code = 5'd12;
      cycle();
      exc_req = 1'b0;
      sb_pop(32'(redirect));
      rd(0, 5'd14, 32'h200, "nest_epc_kept");
      rd(0, 5'd13, 32'hC30, "nest_cause");
      rd(0, 5'd12, 32'h402, "nest_status");

      int_in = '0;
      sb_push("hw_eret_redirect_pc", 32'h200);
      eret = 1'b1;
      cycle();
      eret = 1'b0;
      sb_pop(redirect_pc);
      rd(0, 5'd12, 32'h401, "hw_eret_status");

      // Entry beats eret and mtc0 in the same cycle
      sb_push("prio_redirect", 32'h1);
      sb_push("prio_redirect_pc", 32'h0000_F000);
      pc = 32'h400; exc_req = 1'b1; exc_code = 5'd4; eret = 1'b1;
      mtc0 = 1'b1; reg_addr = 5'd12; wdata = 32'h0000_0019;
      cycle();
      exc_req = 1'b0; eret = 1'b0; mtc0 = 1'b0;
      sb_pop(32'(redirect));
      sb_pop(redirect_pc);
      rd(0, 5'd12, 32'h402, "prio_status");
      rd(0, 5'd14, 32'h400, "prio_epc");
      wr(5'd12, 32'h0);

      // Timer on the COUNT_DIV=1 instance
      wr(5'd11, 32'h1);
      wr(5'd9, 32'hFFFF_FFFE);
      rd(1, 5'd9, 32'hFFFF_FFFE, "tmr_count_load");
      chk_now("tmr_irq_e0", 32'(timer_irq1), 32'h0);
      cycle();
      cycle();
      rd(1, 5'd9, 32'h0, "tmr_count_wrap");
      chk_now("tmr_irq_e2", 32'(timer_irq1), 32'h0);
      cycle();
      chk_now("tmr_irq_e3", 32'(timer_irq1), 32'h1);
      rd(1, 5'd13, 32'h8010, "tmr_cause_ip7");
      cycle();
      chk_now("tmr_irq_sticky", 32'(timer_irq1), 32'h1);
      wr(5'd11, 32'h50);
      chk_now("tmr_irq_cleared", 32'(timer_irq1), 32'h0);

      // Compare write on the matching cycle leaves the flag clear
      wr(5'd11, 32'h13);
      wr(5'd9, 32'h10);
      cycle();
      cycle();
      wr(5'd11, 32'h80);
      chk_now("tmr_match_vs_write", 32'(timer_irq1), 32'h0);
      cycle();
      chk_now("tmr_match_vs_write_after", 32'(timer_irq1), 32'h0);

      // Reset while a redirect is pending
      exc_req = 1'b1; exc_code = 5'd8; pc = 32'h500;
      cycle();
      exc_req = 1'b0;
      chk_now("mid_redirect", 32'(redirect), 32'h1);
      reset = 1'b0;
      cycle();
      chk_now("rst2_redirect", 32'(redirect), 32'h0);
      chk_now("rst2_redirect_pc", redirect_pc, 32'h0);
      chk_now("rst2_ie", 32'(status_ie), 32'h0);
      rd(0, 5'd12, 32'h0, "rst2_status");
      rd(0, 5'd11, 32'hFFFF_FFFF, "rst2_compare");
      rd(0, 5'd13, 32'h0, "rst2_cause");
      rd(0, 5'd14, 32'h0, "rst2_epc");
      rd(1, 5'd9, 32'h0, "rst2_count1");
      rd(1, 5'd11, 32'hFFFF_FFFF, "rst2_compare1");
      reset = 1'b1;
      cycle();

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
